wb_bus_switch_n: RTL
====================

Name: wb_bus_switch_n

Overview:
- Parametrised single-master, N-slave Wishbone classic switch. Next generation of the fixed 1-slave memory switch and 2-slave peripheral switch.
- Sits between a BIU bus port (memory or peripheral) and its slaves.
- Adds a registered request path, an address-field slave decode with decode-error response, a per-transaction ack timeout, and a sticky error-capture register.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..2^IDX_W).
- DATA_W, 32, data width; must be a multiple of 8.
- ADDR_W, 32, address width.
- SEL_LSB, 16, LSB of the slave-index field in master_adr_i.
- IDX_W, 3, width of the slave-index field (master_adr_i[SEL_LSB+IDX_W-1:SEL_LSB]).
- TIMEOUT, 255, maximum wait cycles for a slave ack; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- master_stb_i  in  1  request strobe, held until ack/err.
- master_we_i  in  1  write enable.
- master_adr_i  in  ADDR_W  address.
- master_dat_i  in  DATA_W  write data.
- master_sel_i  in  DATA_W/8  byte select.
- master_dat_o  out  DATA_W  registered read data.
- master_ack_o  out  1  one-cycle completion pulse.
- master_err_o  out  1  one-cycle error pulse (decode or timeout).
- slave_stb_o  out  NUM_SLAVES  per-slave strobe.
- slave_cyc_o  out  NUM_SLAVES  per-slave cycle; equals slave_stb_o.
- slave_we_o  out  1  registered broadcast write enable.
- slave_adr_o  out  ADDR_W  registered broadcast address.
- slave_dat_o  out  DATA_W  registered broadcast write data.
- slave_sel_o  out  DATA_W/8  registered broadcast byte select.
- slave_dat_i  in  NUM_SLAVES*DATA_W  read data; slave k occupies bits [k*DATA_W +: DATA_W].
- slave_ack_i  in  NUM_SLAVES  per-slave ack.
- err_clr_i  in  1  clears the error-capture register.
- err_cause_o  out  2  sticky cause: 00 none, 01 decode, 10 timeout.
- err_adr_o  out  ADDR_W  address of the first captured error.

Behaviour:
- Reset (rst_i low, async): state IDLE; all outputs 0; timeout counter 0; err_cause_o 00; err_adr_o 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - master_stb_i low: stay in IDLE.
  - master_stb_i high: latch we/adr/dat/sel into slave_* regs; idx = index field.
  - idx < NUM_SLAVES: next state BUSY; slave_stb_o[idx] and slave_cyc_o[idx] go high next cycle; counter cleared.
  - idx >= NUM_SLAVES: no slave strobed; next state RESP with master_err_o=1, cause 01.
- BUSY:
  - counter increments each cycle.
  - slave_ack_i[idx] high: capture slave_dat_i[idx] into master_dat_o (reads and writes alike); drop the strobe; next state RESP with master_ack_o=1.
  - counter reaches TIMEOUT with no ack: drop the strobe; RESP with master_err_o=1, cause 10.
  - Ack and timeout in the same cycle: the ack wins.
  - Acks from non-selected slaves are ignored at all times.
  - master_stb_i dropping mid-BUSY does not abort; the transaction completes normally.
- RESP: master_ack_o or master_err_o is high for exactly this one cycle; the other is 0. Return to IDLE. The master must deassert master_stb_i in the cycle after the pulse; a strobe sampled in IDLE is a new request.
- Latency: master stb in cycle 0; slave stb cycles 1..k, where k is the slave's ack cycle; master ack in cycle k+1. Decode error: master_err_o in cycle 1.
- master_dat_o holds its value until the next ack. It is not updated on error.
- Error capture:
  - Updated only when err_cause_o == 00: first error wins; later errors are not recorded.
  - err_clr_i high sets cause 00 and err_adr_o to 0.
  - If err_clr_i and a new error occur in the same cycle, the new error is captured.
- Async reset mid-transaction: strobes drop immediately and no ack is issued.

Test Plan:
- Defaults. Write adr=0x0002_0010, dat=0xDEADBEEF, sel=4'hF. Slave 2 acks 2 cycles after its strobe -> slave_stb_o=4'b0100 for 2 cycles, broadcast bus carries the values, master_ack_o single pulse in cycle 3, master_err_o=0.
- Read adr=0x0003_0000. Slave 3 returns 0x12345678 with ack -> master_dat_o=0x12345678 with master_ack_o. A simultaneous spurious slave_ack_i[0] is ignored.
- adr=0x0005_0000 (idx 5 >= 4) -> no slave_stb_o asserted, master_err_o pulse in cycle 1, err_cause_o=01, err_adr_o=0x0005_0000.
- Slave 1 never acks, TIMEOUT=255 -> slave_stb_o[1] high for 255 cycles then low, master_err_o pulse. err_cause_o stays 01 (sticky from the prior error). After err_clr_i, repeat -> err_cause_o=10, err_adr_o=the slave 1 address.
- Slave 0 acks exactly in the timeout cycle -> master_ack_o=1, master_err_o=0, err_cause_o unchanged.
- Assert rst_i low during BUSY -> all strobes and outputs 0 immediately. After release, a new request to slave 0 completes normally.

Source files
------------

// File: rtl/wb_bus_switch_n_if.sv
// wb_bus_switch_n_if: master-side and slave-side Wishbone signals of the N-slave switch
interface wb_bus_switch_n_if #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
);
    logic                         master_stb_i;
    logic                         master_we_i;
    logic [ADDR_W-1:0]            master_adr_i;
    logic [DATA_W-1:0]            master_dat_i;
    logic [DATA_W/8-1:0]          master_sel_i;
    logic [DATA_W-1:0]            master_dat_o;
    logic                         master_ack_o;
    logic                         master_err_o;
    logic [NUM_SLAVES-1:0]        slave_stb_o;
    logic [NUM_SLAVES-1:0]        slave_cyc_o;
    logic                         slave_we_o;
    logic [ADDR_W-1:0]            slave_adr_o;
    logic [DATA_W-1:0]            slave_dat_o;
    logic [DATA_W/8-1:0]          slave_sel_o;
    logic [NUM_SLAVES*DATA_W-1:0] slave_dat_i;
    logic [NUM_SLAVES-1:0]        slave_ack_i;

    // environment view: the BIU master together with the attached slaves
    modport master (
        output master_stb_i, master_we_i, master_adr_i, master_dat_i, master_sel_i,
        output slave_dat_i, slave_ack_i,
        input  master_dat_o, master_ack_o, master_err_o,
        input  slave_stb_o, slave_cyc_o, slave_we_o, slave_adr_o, slave_dat_o, slave_sel_o
    );

    // switch view: a slave to the BIU, fanning out to the slave ports
    modport slave (
        input  master_stb_i, master_we_i, master_adr_i, master_dat_i, master_sel_i,
        input  slave_dat_i, slave_ack_i,
        output master_dat_o, master_ack_o, master_err_o,
        output slave_stb_o, slave_cyc_o, slave_we_o, slave_adr_o, slave_dat_o, slave_sel_o
    );
endinterface

// File: rtl/wb_bus_switch_n.sv
// wb_bus_switch_n: single-master N-slave Wishbone classic switch with decode error,
// ack timeout and sticky first-error capture
module wb_bus_switch_n #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int SEL_LSB    = 16,
    parameter int IDX_W      = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_bus_switch_n_if.slave  bus,
    input  logic              err_clr_i,
    output logic [1:0]        err_cause_o,
    output logic [ADDR_W-1:0] err_adr_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              sel_ack;
    logic              timeout;
    logic              new_err;
    logic [1:0]        new_cause;
    logic [ADDR_W-1:0] new_adr;
    logic [DATA_W-1:0] rd_dat;

    assign idx       = bus.master_adr_i[SEL_LSB +: IDX_W];
    assign hit       = int'(idx) < NUM_SLAVES;
    // the one-hot strobe doubles as the selected-slave mask, so stray acks never count
    assign sel_ack   = |(bus.slave_ack_i & bus.slave_stb_o);
    assign timeout   = cnt == CW'(TIMEOUT - 1);
    assign new_err   = (state == IDLE && bus.master_stb_i && !hit) ||
                       (state == BUSY && !sel_ack && timeout);
    assign new_cause = state == IDLE ? 2'b01 : 2'b10;
    assign new_adr   = state == IDLE ? bus.master_adr_i : bus.slave_adr_o;
    assign bus.slave_cyc_o = bus.slave_stb_o;

    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            rd_dat = bus.slave_stb_o[k] ? rd_dat | bus.slave_dat_i[k*DATA_W +: DATA_W] : rd_dat;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.master_dat_o <= '0;
            bus.master_ack_o <= 1'b0;
            bus.master_err_o <= 1'b0;
            bus.slave_stb_o  <= '0;
            bus.slave_we_o   <= 1'b0;
            bus.slave_adr_o  <= '0;
            bus.slave_dat_o  <= '0;
            bus.slave_sel_o  <= '0;
            err_cause_o      <= 2'b00;
            err_adr_o        <= '0;
        end else begin
            bus.master_ack_o <= 1'b0;
            bus.master_err_o <= 1'b0;
            if (new_err && (err_cause_o == 2'b00 || err_clr_i)) begin
                err_cause_o <= new_cause;
                err_adr_o   <= new_adr;
            end else if (err_clr_i) begin
                err_cause_o <= 2'b00;
                err_adr_o   <= '0;
            end
            case (state)
                IDLE: if (bus.master_stb_i) begin
                    bus.slave_we_o  <= bus.master_we_i;
                    bus.slave_adr_o <= bus.master_adr_i;
                    bus.slave_dat_o <= bus.master_dat_i;
                    bus.slave_sel_o <= bus.master_sel_i;
                    cnt             <= '0;
                    if (hit) begin
                        bus.slave_stb_o <= NUM_SLAVES'(1) << idx;
                        state           <= BUSY;
                    end else begin
                        bus.master_err_o <= 1'b1;
                        state            <= RESP;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (sel_ack) begin
                        bus.master_dat_o <= rd_dat;
                        bus.slave_stb_o  <= '0;
                        bus.master_ack_o <= 1'b1;
                        state            <= RESP;
                    end else if (timeout) begin
                        bus.slave_stb_o  <= '0;
                        bus.master_err_o <= 1'b1;
                        state            <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
